// File: rtl/instruction_fetch_unit.sv
// Prefetching fetch stage: issues sequential reads to a 1-cycle synchronous instruction memory,
// buffers returned words in a FIFO and hands {instr, instr_pc} to decode. Optional macro: IFU_BYPASS_EN.
module instruction_fetch_unit #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rd_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted,
    output logic              dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW+1:0] DEPTH_V = (PW+2)'(DEPTH);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HALT  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic                r_inflight;
    logic [ADDR_W-1:0]   r_infl_pc;
    logic [DATA_W-1:0]   r_fifo_data [DEPTH];
    logic [ADDR_W-1:0]   r_fifo_pc   [DEPTH];
    logic [PW-1:0]       r_rd_ptr;
    logic [PW-1:0]       r_wr_ptr;
    logic [PW:0]         r_count;

    logic [PW+1:0]       w_used;
    logic                w_issue;
    logic                w_resp;
    logic                w_fifo_valid;
    logic                w_bypass;
    logic                w_push;
    logic                w_pop;

    // Credits use the start-of-cycle occupancy plus the outstanding read, so a
    // same-cycle pop never frees a slot early and a response always has room.
    assign w_used       = {1'b0, r_count} + {{(PW+1){1'b0}}, r_inflight};
    assign w_issue      = !reset && (r_state == S_FETCH) && !redirect && (w_used < DEPTH_V);
    assign w_resp       = !reset && r_inflight && (r_state == S_FETCH) && !redirect;
    assign w_fifo_valid = (r_count != '0);

`ifdef IFU_BYPASS_EN
    assign w_bypass = w_resp && !w_fifo_valid;
`else
    assign w_bypass = 1'b0;
`endif

    // Decode handshake: a word transfers on a cycle where instr_valid && instr_ready;
    // while instr_valid && !instr_ready the offered word is held unchanged.
    assign w_pop  = w_fifo_valid && instr_ready;
    assign w_push = w_resp && !(w_bypass && instr_ready);

    assign imem_rd_en = w_issue;
    assign imem_addr  = r_fetch_pc;
    assign halted     = (r_state == S_HALT);
    assign dbg_state  = r_state;

    always_comb begin
        instr_valid = 1'b0;
        instr       = '0;
        instr_pc    = '0;
        if (w_fifo_valid) begin
            instr_valid = 1'b1;
            instr       = r_fifo_data[r_rd_ptr];
            instr_pc    = r_fifo_pc[r_rd_ptr];
        end else if (w_bypass) begin
            instr_valid = 1'b1;
            instr       = imem_rd_data;
            instr_pc    = r_infl_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !redirect) begin
            r_fifo_data[r_wr_ptr] <= imem_rd_data;
            r_fifo_pc[r_wr_ptr]   <= r_infl_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_infl_pc  <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_infl_pc <= r_fetch_pc;
            end

            if (redirect) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
            end

            case (r_state)
                S_FETCH: begin
                    if (w_resp && (imem_rd_data == HALT_WORD)) begin
                        r_state <= S_HALT;
                    end
                end
                S_HALT: begin
                    if (redirect) begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase

            // A same-cycle transfer still completes; the flush then empties the FIFO.
            if (redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (PW+1)'(1);
                    2'b01:   r_count <= r_count - (PW+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized ready/redirect traffic
// checked against a program-order model of fetch and delivery.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

`ifdef IFU_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       imem_rd_en;
    logic [7:0] imem_addr;
    logic [7:0] imem_rd_data;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       halted;
    logic       dbg_state;

    logic       w_rd_en;
    logic [7:0] w_addr;
    logic [7:0] w_rd_data;
    logic       w_valid;
    logic [7:0] w_instr;
    logic [7:0] w_pc;
    logic       w_halted;
    logic       w_dbg;

    logic [7:0] mem [256];

    // clock / reset block
    always #5 clk = ~clk;

    instruction_fetch_unit u_dut (
        .clk(clk), .reset(reset),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rd_data(imem_rd_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .halted(halted), .dbg_state(dbg_state)
    );

    instruction_fetch_unit #(.RESET_PC(8'hFE)) u_dut_wrap (
        .clk(clk), .reset(reset),
        .imem_rd_en(w_rd_en), .imem_addr(w_addr), .imem_rd_data(w_rd_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(w_valid), .instr_ready(instr_ready),
        .instr(w_instr), .instr_pc(w_pc), .halted(w_halted), .dbg_state(w_dbg)
    );

    // 1-cycle synchronous instruction memories
    always_ff @(posedge clk) begin
        if (imem_rd_en) imem_rd_data <= mem[imem_addr];
        if (w_rd_en)    w_rd_data    <= mem[w_addr];
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc_n    = 0;
    int         n_deliv  = 0;

    logic       reset_q, redir_q, ready_q;
    logic [7:0] redir_pc_q;

    logic [7:0] exp_pc, exp_fetch;
    logic       stopped;
    logic       prev_hold;
    logic [7:0] prev_instr, prev_pc;

    logic [7:0] exp_q [$];
    logic [7:0] wrap_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    function automatic bit halt_pending();
        logic [7:0] p;
        p = exp_pc;
        for (int k = 0; k < 256 && p != exp_fetch; k++) begin
            if (mem[p] == 8'h00) return 1'b1;
            p = p + 8'd1;
        end
        return stopped;
    endfunction

    task automatic model_reset();
        exp_pc    = 8'h00;
        exp_fetch = 8'h00;
        stopped   = 1'b0;
        prev_hold = 1'b0;
    endtask

    // Program-order model: fetches are sequential from the last redirect/reset, decode
    // sees mem[pc] for consecutive pcs, and nothing follows a delivered halt word.
    task automatic model_step();
        if (!instr_valid) begin
            check("idle_instr", instr, 0);
            check("idle_pc", instr_pc, 0);
        end
        if (prev_hold) begin
            check("hold_valid", instr_valid, 1);
            check("hold_instr", instr, prev_instr);
            check("hold_pc", instr_pc, prev_pc);
        end
        if (redirect) check("redir_no_fetch", imem_rd_en, 0);
        if (halted) begin
            check("halt_no_fetch", imem_rd_en, 0);
            check("halt_pending", halt_pending(), 1);
        end
        if (stopped) check("halt_flag", halted, 1);
        if (imem_rd_en) begin
            check("fetch_addr", imem_addr, exp_fetch);
            exp_fetch = exp_fetch + 8'd1;
        end
        if (instr_valid && instr_ready) begin
            check("deliv_after_halt", stopped, 0);
            check("deliv_pc", instr_pc, exp_pc);
            check("deliv_instr", instr, mem[exp_pc]);
            if (mem[exp_pc] == 8'h00) stopped = 1'b1;
            exp_pc = exp_pc + 8'd1;
            n_deliv++;
        end
        prev_hold  = instr_valid && !instr_ready && !redirect;
        prev_instr = instr;
        prev_pc    = instr_pc;
        if (redirect) begin
            exp_pc    = redirect_pc;
            exp_fetch = redirect_pc;
            stopped   = 1'b0;
        end
    endtask

    // driver: apply inputs on the falling edge, observe 1ns later
    task automatic cycle();
        @(negedge clk);
        reset       = reset_q;
        redirect    = redir_q;
        redirect_pc = redir_pc_q;
        instr_ready = ready_q;
        #1;
        cyc_n++;
        if (!reset_q && w_rd_en) wrap_q.push_back(w_addr);
        if (reset_q) model_reset();
        else model_step();
    endtask

    task automatic reset_dut();
        reset_q = 1'b1;
        redir_q = 1'b0;
        cycle();
        cycle();
        check("rst_rd_en", imem_rd_en, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_halted", halted, 0);
        reset_q = 1'b0;
    endtask

    task automatic load_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        mem[3] = 8'h44; mem[4] = 8'h55; mem[5] = 8'h66;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t2_exp [4];
        int  n_rd, n, seen, found;
        t2_exp[0] = 8'h11; t2_exp[1] = 8'h22; t2_exp[2] = 8'h33; t2_exp[3] = 8'h44;

        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        reset_q = 1'b1; redir_q = 1'b0; redir_pc_q = '0; ready_q = 1'b0;
        load_mem();
        model_reset();

        // T1: streaming with ready=1
        reset_dut();
        ready_q = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("t1_rd_en", imem_rd_en, 1);
            check("t1_addr", imem_addr, k);
            if (k < LAT) begin
                check("t1_valid_early", instr_valid, 0);
            end else begin
                check("t1_valid", instr_valid, 1);
                check("t1_instr", instr, mem[k - LAT]);
                check("t1_pc", instr_pc, k - LAT);
            end
        end

        // T2: decode stalled, FIFO fills to exactly DEPTH; wrap instance fetches FE..01
        reset_dut();
        ready_q = 1'b0;
        wrap_q.delete();
        exp_q.delete();
        exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        n_rd = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (imem_rd_en) n_rd++;
        end
        check("t2_reads", n_rd, 4);
        check("t2_hold_valid", instr_valid, 1);
        check("t2_hold_instr", instr, 8'h11);
        check("t2_hold_pc", instr_pc, 0);
        check("wrap_count", wrap_q.size(), exp_q.size());
        while (exp_q.size() > 0 && wrap_q.size() > 0) begin
            check("wrap_addr", wrap_q.pop_front(), exp_q.pop_front());
        end
        ready_q = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("t2_valid", instr_valid, 1);
            check("t2_instr", instr, t2_exp[k]);
            check("t2_pc", instr_pc, k);
        end

        // T3: redirect with one FIFO entry and one response in flight
        reset_dut();
        ready_q = 1'b0;
        cycle();
        cycle();
        redir_q = 1'b1; redir_pc_q = 8'h40;
        cycle();
        check("t3_redir_rd_en", imem_rd_en, 0);
        redir_q = 1'b0; ready_q = 1'b1;
        n = 0; seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            cycle();
            n++;
            if (instr_valid) seen = 1;
        end
        check("t3_seen", seen, 1);
        check("t3_latency", n, LAT + 1);
        check("t3_pc", instr_pc, 8'h40);
        check("t3_instr", instr, mem[8'h40]);

        // T4: halt word at pc 5, then redirect to 8
        mem[5] = 8'h00;
        reset_dut();
        ready_q = 1'b1;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cycle();
            if (instr_valid && instr_pc == 8'd5) found = 1;
        end
        check("t4_found", found, 1);
        check("t4_instr", instr, 8'h00);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("t4_halted", halted, 1);
            check("t4_rd_en", imem_rd_en, 0);
            check("t4_valid", instr_valid, 0);
        end
        redir_q = 1'b1; redir_pc_q = 8'h08;
        cycle();
        redir_q = 1'b0;
        cycle();
        check("t4_resume_halted", halted, 0);
        check("t4_resume_rd_en", imem_rd_en, 1);
        check("t4_resume_addr", imem_addr, 8'h08);
        mem[5] = 8'h66;

        // Randomized traffic: random program with halt words, random stalls and redirects
        for (int i = 0; i < 256; i++) begin
            mem[i] = ($urandom_range(0, 11) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        end
        reset_dut();
        n_deliv = 0;
        for (int k = 0; k < 3000; k++) begin
            ready_q    = ($urandom_range(0, 9) < 7);
            redir_q    = ($urandom_range(0, 39) == 0);
            redir_pc_q = 8'($urandom_range(0, 255));
            cycle();
        end
        redir_q = 1'b0;
        check("rand_progress", (n_deliv > 200), 1);

        // reset in the middle of traffic
        ready_q = 1'b1;
        reset_dut();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
